// File: rtl/score_controller_pkg.sv
// Shared types for the score controller: FSM states, BCD digit and binary score widths,
// winner codes and the display codes shared with the display rotator.
package scoreboard_pkg;

  localparam int DIGIT_W = 4;
  localparam int BIN_W   = 7;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [BIN_W-1:0]   bin_t;

  localparam digit_t DIGIT_OFF = 4'd10;
  localparam digit_t DIGIT_P   = 4'd11;
  localparam bin_t   SCORE_MAX = 7'd99;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_LOCK = 2'd1,
    ST_WON  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  // 8-bit compare so opp + margin cannot wrap near 99.
  function automatic logic has_won(bin_t me, bin_t opp, bin_t win_score, bin_t margin);
    return (me >= win_score) && ({1'b0, me} >= ({1'b0, opp} + {1'b0, margin}));
  endfunction

endpackage

// File: rtl/score_controller_if.sv
// Button-pulse inputs and score/serve/result outputs of the score controller.
interface score_controller_if;
  import scoreboard_pkg::*;

  logic       new_game_i;
  logic       p1_inc_i;
  logic       p1_dec_i;
  logic       p2_inc_i;
  logic       p2_dec_i;
  digit_t     p1_tens_o;
  digit_t     p1_ones_o;
  digit_t     p2_tens_o;
  digit_t     p2_ones_o;
  logic       serve_o;
  logic       game_over_o;
  logic [1:0] winner_o;

  modport master (
    output new_game_i, p1_inc_i, p1_dec_i, p2_inc_i, p2_dec_i,
    input  p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o, serve_o, game_over_o, winner_o
  );

  modport slave (
    input  new_game_i, p1_inc_i, p1_dec_i, p2_inc_i, p2_dec_i,
    output p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o, serve_o, game_over_o, winner_o
  );

endinterface

// File: rtl/score_controller_bcd_counter_2d.sv
// Two-digit BCD up/down counter with a binary shadow, saturating at 00 and 99.
// accepted_o flags a step that actually changes the count; clr_i > dec_i > inc_i.
module bcd_counter_2d
  import scoreboard_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   clr_i,
  input  logic   inc_i,
  input  logic   dec_i,
  output digit_t tens_o,
  output digit_t ones_o,
  output bin_t   bin_o,
  output bin_t   bin_nxt_o,
  output logic   accepted_o
);

  digit_t tens_q, tens_d;
  digit_t ones_q, ones_d;
  bin_t   bin_q, bin_d;
  logic   acc;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    bin_d  = bin_q;
    acc    = 1'b0;
    if (clr_i) begin
      tens_d = '0;
      ones_d = '0;
      bin_d  = '0;
    end else if (dec_i) begin
      if (bin_q != '0) begin
        acc   = 1'b1;
        bin_d = bin_q - bin_t'(1);
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end else if (inc_i) begin
      if (bin_q != SCORE_MAX) begin
        acc   = 1'b1;
        bin_d = bin_q + bin_t'(1);
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tens_q <= '0;
      ones_q <= '0;
      bin_q  <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
      bin_q  <= bin_d;
    end
  end

  assign tens_o     = tens_q;
  assign ones_o     = ones_q;
  assign bin_o      = bin_q;
  assign bin_nxt_o  = bin_d;
  assign accepted_o = acc;

endmodule

// File: rtl/score_controller.sv
// Table-tennis rule engine: decodes point/undo pulses, applies a post-point lockout,
// tracks serve and detects game end; all outputs registered.
module score_controller
  import scoreboard_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int WIN_MARGIN  = 2,
  parameter int SERVE_SHIFT = 1,
  parameter int LOCKOUT_MS  = 300
) (
  input logic               clk_1khz,
  input logic               rst_n_i,
  score_controller_if.slave bus
);

  localparam int CW = (LOCKOUT_MS > 1) ? $clog2(LOCKOUT_MS) : 1;

  state_e          state_q;
  logic [CW-1:0]   lock_cnt_q;
  logic            serve_q, serve_d;
  logic            over_q;
  winner_e         winner_q;

  logic [2:0]      n_evt;
  logic            one_evt;
  logic            p1_acc, p2_acc;
  bin_t            p1_bin, p2_bin, p1_nxt, p2_nxt;
  logic [7:0]      total;
  logic            deuce;

  // Two or more simultaneous pulses are treated as a bounce and dropped entirely.
  assign n_evt   = {2'b0, bus.p1_inc_i} + {2'b0, bus.p1_dec_i}
                 + {2'b0, bus.p2_inc_i} + {2'b0, bus.p2_dec_i};
  assign one_evt = (n_evt == 3'd1);

  bcd_counter_2d u_p1 (
    .clk_i      (clk_1khz),
    .rst_n_i    (rst_n_i),
    .clr_i      (bus.new_game_i),
    .inc_i      (one_evt && bus.p1_inc_i && (state_q == ST_PLAY)),
    .dec_i      (one_evt && bus.p1_dec_i && (state_q != ST_LOCK)),
    .tens_o     (bus.p1_tens_o),
    .ones_o     (bus.p1_ones_o),
    .bin_o      (p1_bin),
    .bin_nxt_o  (p1_nxt),
    .accepted_o (p1_acc)
  );

  bcd_counter_2d u_p2 (
    .clk_i      (clk_1khz),
    .rst_n_i    (rst_n_i),
    .clr_i      (bus.new_game_i),
    .inc_i      (one_evt && bus.p2_inc_i && (state_q == ST_PLAY)),
    .dec_i      (one_evt && bus.p2_dec_i && (state_q != ST_LOCK)),
    .tens_o     (bus.p2_tens_o),
    .ones_o     (bus.p2_ones_o),
    .bin_o      (p2_bin),
    .bin_nxt_o  (p2_nxt),
    .accepted_o (p2_acc)
  );

  // Serve is derived from the next score so it changes on the same edge as the digits.
  assign total   = {1'b0, p1_nxt} + {1'b0, p2_nxt};
  assign deuce   = (p1_nxt >= bin_t'(WIN_SCORE - 1)) && (p2_nxt >= bin_t'(WIN_SCORE - 1));
  assign serve_d = deuce ? total[0] : total[SERVE_SHIFT];

  always_ff @(posedge clk_1khz) begin
    if (!rst_n_i) begin
      state_q    <= ST_PLAY;
      lock_cnt_q <= '0;
      serve_q    <= 1'b0;
      over_q     <= 1'b0;
      winner_q   <= WIN_NONE;
    end else begin
      serve_q <= serve_d;
      if (bus.new_game_i) begin
        state_q    <= ST_PLAY;
        lock_cnt_q <= '0;
        over_q     <= 1'b0;
        winner_q   <= WIN_NONE;
      end else begin
        case (state_q)
          ST_PLAY, ST_WON: begin
            if (p1_acc || p2_acc) begin
              state_q    <= ST_LOCK;
              lock_cnt_q <= CW'(LOCKOUT_MS - 1);
              over_q     <= 1'b0;
              winner_q   <= WIN_NONE;
            end
          end
          ST_LOCK: begin
            if (lock_cnt_q == '0) begin
              if (has_won(p1_bin, p2_bin, bin_t'(WIN_SCORE), bin_t'(WIN_MARGIN))) begin
                state_q  <= ST_WON;
                over_q   <= 1'b1;
                winner_q <= WIN_P1;
              end else if (has_won(p2_bin, p1_bin, bin_t'(WIN_SCORE), bin_t'(WIN_MARGIN))) begin
                state_q  <= ST_WON;
                over_q   <= 1'b1;
                winner_q <= WIN_P2;
              end else begin
                state_q  <= ST_PLAY;
              end
            end else begin
              lock_cnt_q <= lock_cnt_q - CW'(1);
            end
          end
          default: state_q <= ST_PLAY;
        endcase
      end
    end
  end

  assign bus.serve_o     = serve_q;
  assign bus.game_over_o = over_q;
  assign bus.winner_o    = winner_q;

endmodule

// File: tb/tb_score_controller.sv
// Directed plus randomized bench for score_controller, checked against a cycle-level rule model.
module tb_score_controller;

  localparam int LOCK_A = 5;
  localparam int LOCK_B = 50;

  logic clk;
  logic rst_n;
  int   n_total, n_pass, n_fail;

  // Rule model: scores as integers, lockout as an absolute "ends at edge N" deadline.
  int   m1, m2, m_win, edge_n, lock_end;
  bit   m_over, m_serve, m_locked;

  score_controller_if ifa();
  score_controller_if ifb();

  score_controller #(.LOCKOUT_MS(LOCK_A)) dut_a (.clk_1khz(clk), .rst_n_i(rst_n), .bus(ifa));
  score_controller #(.LOCKOUT_MS(LOCK_B)) dut_b (.clk_1khz(clk), .rst_n_i(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit serve_of(input int a, input int b);
    int t = a + b;
    if (a >= 10 && b >= 10) return bit'(t % 2);
    return bit'((t / 2) % 2);
  endfunction

  task automatic model_step(input bit rst_v, ng, a_i, a_d, b_i, b_d);
    int n;
    bit acc;
    if (!rst_v || ng) begin
      m1 = 0; m2 = 0; m_over = 0; m_win = 0; m_serve = 0; m_locked = 0;
    end else if (m_locked) begin
      if (edge_n == lock_end) begin
        m_locked = 0;
        if (m1 >= 11 && m1 >= m2 + 2) begin m_over = 1; m_win = 1; end
        else if (m2 >= 11 && m2 >= m1 + 2) begin m_over = 1; m_win = 2; end
      end
    end else begin
      n = int'(a_i) + int'(a_d) + int'(b_i) + int'(b_d);
      acc = 0;
      if (n == 1) begin
        if (a_d && m1 > 0) begin m1--; acc = 1; end
        if (b_d && m2 > 0) begin m2--; acc = 1; end
        if (!m_over && a_i && m1 < 99) begin m1++; acc = 1; end
        if (!m_over && b_i && m2 < 99) begin m2++; acc = 1; end
      end
      if (acc) begin
        m_locked = 1;
        lock_end = edge_n + LOCK_A;
        m_over   = 0;
        m_win    = 0;
        m_serve  = serve_of(m1, m2);
      end
    end
  endtask

  task automatic check_all();
    chk("p1_tens", 8'(ifa.p1_tens_o), 8'(m1 / 10));
    chk("p1_ones", 8'(ifa.p1_ones_o), 8'(m1 % 10));
    chk("p2_tens", 8'(ifa.p2_tens_o), 8'(m2 / 10));
    chk("p2_ones", 8'(ifa.p2_ones_o), 8'(m2 % 10));
    chk("serve", 8'(ifa.serve_o), 8'(m_serve));
    chk("game_over", 8'(ifa.game_over_o), 8'(m_over));
    chk("winner", 8'(ifa.winner_o), 8'(m_win));
  endtask

  task automatic tick(input bit rst_v, ng, a_i, a_d, b_i, b_d);
    @(negedge clk);
    rst_n = rst_v;
    ifa.new_game_i = ng;
    ifa.p1_inc_i = a_i;
    ifa.p1_dec_i = a_d;
    ifa.p2_inc_i = b_i;
    ifa.p2_dec_i = b_d;
    @(posedge clk);
    edge_n++;
    model_step(rst_v, ng, a_i, a_d, b_i, b_d);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0);
  endtask

  // One event followed by enough idle cycles to clear the lockout.
  task automatic point(input bit a_i, a_d, b_i, b_d);
    tick(1, 0, a_i, a_d, b_i, b_d);
    idle(LOCK_A + 1);
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0; edge_n = 0; lock_end = 0;
    m1 = 0; m2 = 0; m_win = 0; m_over = 0; m_serve = 0; m_locked = 0;
    rst_n = 1'b0;
    ifa.new_game_i = 0; ifa.p1_inc_i = 0; ifa.p1_dec_i = 0; ifa.p2_inc_i = 0; ifa.p2_dec_i = 0;
    ifb.new_game_i = 0; ifb.p1_inc_i = 0; ifb.p1_dec_i = 0; ifb.p2_inc_i = 0; ifb.p2_dec_i = 0;

    // Reset from arbitrary scores.
    tick(0, 0, 0, 0, 0, 0);
    point(1, 0, 0, 0); point(0, 0, 1, 0); point(1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("rst_p1_ones", 8'(ifa.p1_ones_o), 8'd0);
    chk("rst_serve", 8'(ifa.serve_o), 8'd0);

    // Eleven straight points win; the twelfth is ignored.
    for (int i = 0; i < 11; i++) begin
      tick(1, 0, 1, 0, 0, 0);
      idle(9);
    end
    chk("p1_11_tens", 8'(ifa.p1_tens_o), 8'd1);
    chk("p1_11_ones", 8'(ifa.p1_ones_o), 8'd1);
    chk("win11_over", 8'(ifa.game_over_o), 8'd1);
    chk("win11_winner", 8'(ifa.winner_o), 8'd1);
    point(1, 0, 0, 0);
    chk("p1_12th_ignored", 8'(ifa.p1_ones_o), 8'd1);

    // Deuce: 10-10 then P1, P2, P1, P1.
    tick(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      point(1, 0, 0, 0);
      point(0, 0, 1, 0);
    end
    chk("deuce_serve_20", 8'(ifa.serve_o), 8'd0);
    point(1, 0, 0, 0);
    chk("deuce_serve_21", 8'(ifa.serve_o), 8'd1);
    chk("no_win_11_10", 8'(ifa.game_over_o), 8'd0);
    point(0, 0, 1, 0);
    point(1, 0, 0, 0);
    chk("no_win_12_11", 8'(ifa.game_over_o), 8'd0);
    point(1, 0, 0, 0);
    chk("win_13_11", 8'(ifa.winner_o), 8'd1);

    // Long lockout on the second instance.
    tick(1, 0, 0, 0, 0, 0);
    ifb.p1_inc_i = 1;
    tick(1, 0, 0, 0, 0, 0);
    ifb.p1_inc_i = 0;
    chk("lockb_first", 8'(ifb.p1_ones_o), 8'd1);
    idle(2);
    ifb.p1_inc_i = 1;
    tick(1, 0, 0, 0, 0, 0);
    ifb.p1_inc_i = 0;
    chk("lockb_second_ignored", 8'(ifb.p1_ones_o), 8'd1);
    idle(56);
    ifb.p1_inc_i = 1;
    tick(1, 0, 0, 0, 0, 0);
    ifb.p1_inc_i = 0;
    chk("lockb_third_tens", 8'(ifb.p1_tens_o), 8'd0);
    chk("lockb_third_ones", 8'(ifb.p1_ones_o), 8'd2);

    // Simultaneous pulses are dropped without a lockout.
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 1, 0);
    chk("multi_p1", 8'(ifa.p1_ones_o), 8'd0);
    tick(1, 0, 0, 0, 1, 0);
    chk("after_multi_p2", 8'(ifa.p2_ones_o), 8'd1);
    idle(LOCK_A + 1);
    tick(1, 1, 1, 0, 0, 0);
    chk("ng_over_inc_p1", 8'(ifa.p1_ones_o), 8'd0);
    chk("ng_over_inc_p2", 8'(ifa.p2_ones_o), 8'd0);

    // Undo out of WON, and undo at zero.
    for (int i = 0; i < 5; i++) point(0, 0, 1, 0);
    for (int i = 0; i < 11; i++) point(1, 0, 0, 0);
    chk("won_11_5", 8'(ifa.game_over_o), 8'd1);
    tick(1, 0, 0, 1, 0, 0);
    chk("undo_p1_ones", 8'(ifa.p1_ones_o), 8'd0);
    chk("undo_over_drop", 8'(ifa.game_over_o), 8'd0);
    idle(LOCK_A + 1);
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 1, 0, 0, 0);
    chk("dec0_no_lock", 8'(ifa.p1_ones_o), 8'd1);
    idle(LOCK_A + 1);

    // Random pulses, occasional multi-pulse, new game and reset.
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit a_i, a_d, b_i, b_d;
      r   = int'($urandom_range(0, 199));
      a_i = ($urandom_range(0, 99) < 30);
      a_d = ($urandom_range(0, 99) < 6);
      b_i = ($urandom_range(0, 99) < 20);
      b_d = ($urandom_range(0, 99) < 6);
      if (r == 0) tick(0, 0, a_i, a_d, b_i, b_d);
      else if (r < 3) tick(1, 1, a_i, a_d, b_i, b_d);
      else tick(1, 0, a_i, a_d, b_i, b_d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
